// File: rtl/prbs23_pkg.sv
// rtl/prbs23_pkg.sv - PRBS23 constants and frame-generator FSM state type
package prbs23_pkg;

    localparam int PRBS_W = 23;
    localparam int TAP_A  = 22;
    localparam int TAP_B  = 17;
    localparam logic [PRBS_W-1:0] PRBS_SEED = 23'h7FFFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_GAP
    } state_t;

endpackage

// File: rtl/prbs23_frame_gen_if.sv
// rtl/prbs23_frame_gen_if.sv - byte stream interface with first/last-of-frame flags
interface prbs23_frame_gen_if;

    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic       tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);

endinterface

// File: rtl/prbs23_step8.sv
// rtl/prbs23_step8.sv - eight unrolled x^23+x^18+1 steps, first step lands in bit 0
module prbs23_step8
    import prbs23_pkg::*;
(
    input  logic [PRBS_W-1:0] s_in,
    output logic [PRBS_W-1:0] s_out,
    output logic [7:0]        prbs_byte
);

    logic [PRBS_W-1:0] s;
    logic              b;

    always_comb begin
        s         = s_in;
        b         = 1'b0;
        prbs_byte = 8'h00;
        for (int i = 0; i < 8; i++) begin
            b            = s[TAP_A] ^ s[TAP_B];
            prbs_byte[i] = b;
            s            = {s[PRBS_W-2:0], b};
        end
        s_out = s;
    end

endmodule

// File: rtl/prbs23_frame_gen.sv
// rtl/prbs23_frame_gen.sv - PRBS23 test-traffic source framed into fixed-length packets
module prbs23_frame_gen
    import prbs23_pkg::*;
#(
    parameter int FRAME_LEN = 1920,
    parameter int GAP_CYC   = 16,
    parameter int CNT_W     = 16
) (
    input  logic               clk_hh,
    input  logic               rst,
    input  logic               ena,
    input  logic               err_inj,
    prbs23_frame_gen_if.master m_axis,
    output logic [CNT_W-1:0]   n_frames,
    output logic [CNT_W-1:0]   n_inj,
    output logic               busy
);

    localparam int BC_W     = $clog2(FRAME_LEN);
    localparam int GC_W     = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
    localparam int GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

    state_t            state;
    logic [PRBS_W-1:0] prbs_s;
    logic [PRBS_W-1:0] step_s;
    logic [7:0]        step_byte;
    logic [BC_W-1:0]   byte_cnt;
    logic [GC_W-1:0]   gap_cnt;
    logic              inj_pend;
    logic              cur_corrupt;
    logic              hs;
    logic              at_last;
    logic              gap_done;
    logic              start_frame;
    logic              next_byte;
    logic              load;
    logic              corrupt_now;

    // prbs_s always points at the byte to be loaded next, so the output register
    // already holds the current byte and the LFSR moves only when a byte is consumed.
    prbs23_step8 u_step (
        .s_in      (prbs_s),
        .s_out     (step_s),
        .prbs_byte (step_byte)
    );

    assign hs          = m_axis.tvalid & m_axis.tready;
    assign at_last     = (byte_cnt == BC_W'(FRAME_LEN - 1));
    assign gap_done    = (state == ST_GAP) && (gap_cnt == GC_W'(GAP_LAST));
    assign start_frame = ena && ((state == ST_IDLE) || gap_done ||
                                 ((state == ST_RUN) && hs && at_last && (GAP_CYC == 0)));
    assign next_byte   = (state == ST_RUN) && hs && !at_last;
    assign load        = start_frame || next_byte;
    assign corrupt_now = inj_pend || err_inj;
    assign busy        = (state != ST_IDLE);

    always_ff @(posedge clk_hh) begin
        if (rst) begin
            state         <= ST_IDLE;
            prbs_s        <= PRBS_SEED;
            byte_cnt      <= '0;
            gap_cnt       <= '0;
            inj_pend      <= 1'b0;
            cur_corrupt   <= 1'b0;
            m_axis.tdata  <= 8'h00;
            m_axis.tvalid <= 1'b0;
            m_axis.tlast  <= 1'b0;
            m_axis.tuser  <= 1'b0;
            n_frames      <= '0;
            n_inj         <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                end
                ST_RUN: begin
                    if (hs && at_last) begin
                        n_frames      <= n_frames + 1'b1;
                        m_axis.tvalid <= 1'b0;
                        m_axis.tlast  <= 1'b0;
                        m_axis.tuser  <= 1'b0;
                        gap_cnt       <= '0;
                        state         <= (GAP_CYC > 0) ? ST_GAP : ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (gap_done) state <= ST_IDLE;
                    else          gap_cnt <= gap_cnt + 1'b1;
                end
                default: state <= ST_IDLE;
            endcase

            if (hs && cur_corrupt) n_inj <= n_inj + 1'b1;

            // The error is attached when a byte is loaded so tdata never changes under a stall.
            if (load) begin
                state         <= ST_RUN;
                prbs_s        <= step_s;
                m_axis.tdata  <= step_byte ^ {7'b0, corrupt_now};
                m_axis.tvalid <= 1'b1;
                m_axis.tuser  <= start_frame;
                m_axis.tlast  <= !start_frame && (byte_cnt == BC_W'(FRAME_LEN - 2));
                byte_cnt      <= start_frame ? '0 : byte_cnt + 1'b1;
                cur_corrupt   <= corrupt_now;
                inj_pend      <= 1'b0;
            end else begin
                if (hs) cur_corrupt <= 1'b0;
                // A request landing while the corrupted byte still waits is merged into it.
                if (err_inj && !(cur_corrupt && !hs)) inj_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prbs23_frame_gen.sv
// tb/tb_prbs23_frame_gen.sv - scoreboard bench for the PRBS23 frame generator
module tb_prbs23_frame_gen;
    import prbs23_pkg::*;

    localparam int FRAME_LEN = 1920;
    localparam int GAP_CYC   = 16;
    localparam int CNT_W     = 16;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
    } exp_t;

    logic             clk_hh  = 1'b0;
    logic             rst     = 1'b1;
    logic             ena     = 1'b0;
    logic             err_inj = 1'b0;
    logic [CNT_W-1:0] n_frames;
    logic [CNT_W-1:0] n_inj;
    logic             busy;
    logic             rdy_rand = 1'b0;

    prbs23_frame_gen_if axis ();

    prbs23_frame_gen #(
        .FRAME_LEN (FRAME_LEN),
        .GAP_CYC   (GAP_CYC),
        .CNT_W     (CNT_W)
    ) dut (
        .clk_hh   (clk_hh),
        .rst      (rst),
        .ena      (ena),
        .err_inj  (err_inj),
        .m_axis   (axis),
        .n_frames (n_frames),
        .n_inj    (n_inj),
        .busy     (busy)
    );

    always #5 clk_hh = ~clk_hh;

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        exp_q[$];
    logic [22:0] g_s = PRBS_SEED;
    logic [7:0]  first_bytes[3];
    int          first_n   = 0;
    int          frame_idx = 0;
    logic [22:0] chk_s = PRBS_SEED;
    logic [22:0] chk_next;
    logic [7:0]  chk_byte;
    int          chk_err = 0;

    prbs23_step8 u_chk (.s_in(chk_s), .s_out(chk_next), .prbs_byte(chk_byte));

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input int corrupt_idx);
        exp_t       e;
        logic [7:0] d;
        logic       b;
        d = 8'h00;
        for (int k = 0; k < FRAME_LEN; k++) begin
            for (int i = 0; i < 8; i++) begin
                b    = g_s[22] ^ g_s[17];
                d[i] = b;
                g_s  = {g_s[21:0], b};
            end
            e.data = d ^ ((k == corrupt_idx) ? 8'h01 : 8'h00);
            e.last = (k == FRAME_LEN - 1);
            e.user = (k == 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk_hh);
        #1;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int c;
        c = 0;
        while (int'(n_frames) != n && c < budget) begin
            tick();
            c++;
        end
        check("wait_n_frames", int'(n_frames), n);
    endtask

    task automatic wait_idx(input int idx, input int budget);
        int c;
        c = 0;
        while (frame_idx != idx && c < budget) begin
            tick();
            c++;
        end
        check("wait_frame_idx", frame_idx, idx);
    endtask

    task automatic check_first_bytes();
        check("first_n", first_n, 3);
        check("first_byte0", int'(first_bytes[0]), 'h00);
        check("first_byte1", int'(first_bytes[1]), 'h00);
        check("first_byte2", int'(first_bytes[2]), 'h7C);
    endtask

    initial begin
        forever begin
            @(posedge clk_hh);
            #1;
            axis.tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every handshake, tracks stalls, gaps and the RX checker.
    initial begin
        exp_t       e;
        logic       stall_hold;
        logic [9:0] held;
        logic       gap_track;
        logic       gap_ena;
        int         gap_len;
        stall_hold = 1'b0;
        held       = '0;
        gap_track  = 1'b0;
        gap_ena    = 1'b0;
        gap_len    = 0;
        forever begin
            @(negedge clk_hh);
            if (rst) begin
                exp_q.delete();
                first_n    = 0;
                frame_idx  = 0;
                stall_hold = 1'b0;
                gap_track  = 1'b0;
                chk_s      = PRBS_SEED;
                chk_err    = 0;
            end else begin
                if (stall_hold && axis.tvalid)
                    check("stall_stable", int'({axis.tdata, axis.tlast, axis.tuser}), int'(held));
                stall_hold = axis.tvalid && !axis.tready;
                held       = {axis.tdata, axis.tlast, axis.tuser};
                if (gap_track) begin
                    if (!ena) gap_ena = 1'b0;
                    if (!axis.tvalid) begin
                        gap_len++;
                    end else begin
                        if (gap_ena) check("gap_len", gap_len, GAP_CYC);
                        gap_track = 1'b0;
                    end
                end
                if (axis.tvalid && axis.tready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_byte: actual=0x%0h expected=none", axis.tdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("stream_byte", int'({axis.tdata, axis.tlast, axis.tuser}), int'(e));
                    end
                    if (first_n < 3) begin
                        first_bytes[first_n] = axis.tdata;
                        first_n++;
                    end
                    chk_err += $countones(chk_byte ^ axis.tdata);
                    chk_s    = chk_next;
                    if (axis.tlast) begin
                        gap_track = 1'b1;
                        gap_ena   = ena;
                        gap_len   = 0;
                        frame_idx = 0;
                    end else begin
                        frame_idx++;
                    end
                end
            end
        end
    end

    initial begin
        int tv_seen;
        repeat (3) @(posedge clk_hh);
        #1;
        check("rst_tvalid", int'(axis.tvalid), 0);
        check("rst_tdata", int'(axis.tdata), 0);
        check("rst_tlast", int'(axis.tlast), 0);
        check("rst_tuser", int'(axis.tuser), 0);
        check("rst_n_frames", int'(n_frames), 0);
        check("rst_n_inj", int'(n_inj), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;
        for (int f = 0; f < 4; f++) push_frame(-1);

        // Back-to-back frames at full rate, then random backpressure.
        ena = 1'b1;
        tick();
        check("start_tvalid", int'(axis.tvalid), 1);
        check("start_tuser", int'(axis.tuser), 1);
        check("start_busy", int'(busy), 1);
        wait_frames(1, 4000);
        check_first_bytes();
        rdy_rand = 1'b1;
        wait_frames(3, 20000);
        rdy_rand = 1'b0;

        // ena dropped mid-frame: frame completes, gap, then idle.
        wait_idx(100, 3000);
        ena = 1'b0;
        wait_frames(4, 3000);
        repeat (GAP_CYC + 2) tick();
        tv_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (axis.tvalid) tv_seen++;
            tick();
        end
        check("idle_tvalid", tv_seen, 0);
        check("idle_busy", int'(busy), 0);
        check("queue_drained_a", exp_q.size(), 0);

        // One injection in-frame, then two merged requests during the gap.
        push_frame(51);
        push_frame(0);
        ena = 1'b1;
        repeat (51) tick();
        err_inj = 1'b1;
        tick();
        err_inj = 1'b0;
        wait_frames(5, 3000);
        err_inj = 1'b1;
        repeat (2) tick();
        err_inj = 1'b0;
        repeat (20) tick();
        ena = 1'b0;
        wait_frames(6, 3000);
        repeat (GAP_CYC + 4) tick();
        check("n_inj_2", int'(n_inj), 2);
        check("checker_errors", chk_err, 2);
        check("queue_drained_b", exp_q.size(), 0);

        // Reset in the middle of a frame, then restart from the seed.
        push_frame(-1);
        ena = 1'b1;
        repeat (501) tick();
        rst = 1'b1;
        ena = 1'b0;
        tick();
        check("midrst_tvalid", int'(axis.tvalid), 0);
        check("midrst_n_frames", int'(n_frames), 0);
        check("midrst_n_inj", int'(n_inj), 0);
        check("midrst_busy", int'(busy), 0);
        rst = 1'b0;
        g_s = PRBS_SEED;
        push_frame(-1);
        ena = 1'b1;
        tick();
        check("restart_tvalid", int'(axis.tvalid), 1);
        ena = 1'b0;
        wait_frames(1, 3000);
        check_first_bytes();
        repeat (GAP_CYC + 4) tick();
        check("restart_busy", int'(busy), 0);
        check("queue_drained_c", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
